// File: rtl/pll_rst_seq.sv
// pll_rst_seq: PLL reset, lock qualification, retry/fail handling and staggered core/USB reset release.
module pll_rst_seq #(
  parameter int T_PLL_RST = 16,
  parameter int T_LOCK_TO = 4096,
  parameter int T_STABLE  = 64,
  parameter int T_STAGGER = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_reset,
  input  logic       pll_lock,
  output logic       pll_resetb,
  output logic       rst_core,
  output logic       rst_usb,
  output logic       ready,
  output logic       fail,
  output logic [7:0] lock_loss_cnt
);
  localparam int M1 = T_PLL_RST > T_LOCK_TO ? T_PLL_RST : T_LOCK_TO;
  localparam int M2 = T_STABLE > T_STAGGER ? T_STABLE : T_STAGGER;
  localparam int CW = $clog2((M1 > M2 ? M1 : M2) + 1);
  typedef enum logic [2:0] {
    S_PLL_RST, S_WAIT_LOCK, S_STABLE, S_REL_CORE, S_RUN, S_FAIL
  } state_e;
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          sync1_q, lock_q;
  logic          pll_resetb_q, rst_core_q, rst_usb_q, ready_q, fail_q;
  logic          expired;
  // the counter is loaded with the phase length on entry, so the phase ends on the cycle it reads 1
  assign expired = cnt_q == CW'(1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CW'(cnt_q != '0);
    retry_d = retry_q;
    loss_d  = loss_q;
    if (req_reset) begin
      state_d = S_PLL_RST;
      cnt_d   = CW'(T_PLL_RST);
      retry_d = '0;
    end else begin
      case (state_q)
        S_PLL_RST: if (expired) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = CW'(T_LOCK_TO);
        end
        S_WAIT_LOCK: if (lock_q) begin
          state_d = S_STABLE;
          cnt_d   = CW'(T_STABLE);
        end else if (expired) begin
          retry_d = retry_q + 4'd1;
          state_d = (retry_q + 4'd1 == 4'(MAX_RETRY)) ? S_FAIL : S_PLL_RST;
          cnt_d   = CW'(T_PLL_RST);
        end
        S_STABLE: if (!lock_q) begin
          state_d = S_PLL_RST;
          cnt_d   = CW'(T_PLL_RST);
        end else if (expired) begin
          state_d = S_REL_CORE;
          cnt_d   = CW'(T_STAGGER);
        end
        S_REL_CORE, S_RUN: if (!lock_q) begin
          state_d = S_PLL_RST;
          cnt_d   = CW'(T_PLL_RST);
          loss_d  = loss_q + 8'(loss_q != 8'hff);
        end else if (state_q == S_REL_CORE && expired) begin
          state_d = S_RUN;
          retry_d = '0;
        end
        default: state_d = S_FAIL;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_PLL_RST;
      cnt_q        <= CW'(T_PLL_RST);
      retry_q      <= '0;
      loss_q       <= '0;
      sync1_q      <= 1'b0;
      lock_q       <= 1'b0;
      pll_resetb_q <= 1'b0;
      rst_core_q   <= 1'b1;
      rst_usb_q    <= 1'b1;
      ready_q      <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      sync1_q      <= pll_lock;
      lock_q       <= sync1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      pll_resetb_q <= state_d inside {S_WAIT_LOCK, S_STABLE, S_REL_CORE, S_RUN};
      rst_core_q   <= !(state_d inside {S_REL_CORE, S_RUN});
      rst_usb_q    <= state_d != S_RUN;
      ready_q      <= state_d == S_RUN;
      fail_q       <= state_d == S_FAIL;
    end
  end
  assign pll_resetb    = pll_resetb_q;
  assign rst_core      = rst_core_q;
  assign rst_usb       = rst_usb_q;
  assign ready         = ready_q;
  assign fail          = fail_q;
  assign lock_loss_cnt = loss_q;
endmodule

// File: tb/tb_pll_rst_seq.sv
// tb_pll_rst_seq: directed scenarios plus random lock/req_reset/rst traffic against an elapsed-time phase model.
module tb_pll_rst_seq;
  localparam int T_PLL_RST = 4, T_LOCK_TO = 32, T_STABLE = 8, T_STAGGER = 4, MAX_RETRY = 2;
  localparam int PH_PRST = 0, PH_WAIT = 1, PH_STAB = 2, PH_REL = 3, PH_RUN = 4, PH_FAIL = 5;
  logic clk = 1'b0, rst = 1'b1, req_reset = 1'b0, pll_lock = 1'b0;
  logic pll_resetb, rst_core, rst_usb, ready, fail;
  logic [7:0] lock_loss_cnt;
  logic [12:0] act;
  int errors = 0, checks = 0;
  int m_ph = PH_PRST, m_t = 0, m_retry = 0, m_loss = 0;
  bit m_h1 = 1'b0, m_h2 = 1'b0;

  pll_rst_seq #(.T_PLL_RST(T_PLL_RST), .T_LOCK_TO(T_LOCK_TO), .T_STABLE(T_STABLE),
                .T_STAGGER(T_STAGGER), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst(rst), .req_reset(req_reset), .pll_lock(pll_lock),
    .pll_resetb(pll_resetb), .rst_core(rst_core), .rst_usb(rst_usb),
    .ready(ready), .fail(fail), .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk = ~clk;
  assign act = {pll_resetb, rst_core, rst_usb, ready, fail, lock_loss_cnt};

  // phase model: m_t counts cycles spent in the current phase, lock is seen two samples late
  task automatic model_step();
    bit seen, restart;
    int nph;
    seen = m_h2; m_h2 = m_h1; m_h1 = pll_lock;
    if (rst) begin
      m_ph = PH_PRST; m_t = 0; m_retry = 0; m_loss = 0; m_h1 = 0; m_h2 = 0;
      return;
    end
    m_t++;
    nph = m_ph;
    restart = req_reset;
    if (req_reset) begin
      nph = PH_PRST; m_retry = 0;
    end else case (m_ph)
      PH_PRST: if (m_t == T_PLL_RST) nph = PH_WAIT;
      PH_WAIT: if (seen) nph = PH_STAB;
               else if (m_t == T_LOCK_TO) begin
                 if (m_retry + 1 == MAX_RETRY) nph = PH_FAIL;
                 else begin m_retry++; nph = PH_PRST; end
               end
      PH_STAB: if (!seen) nph = PH_PRST; else if (m_t == T_STABLE) nph = PH_REL;
      PH_REL, PH_RUN:
        if (!seen) begin nph = PH_PRST; m_loss = m_loss < 255 ? m_loss + 1 : 255; end
        else if (m_ph == PH_REL && m_t == T_STAGGER) begin nph = PH_RUN; m_retry = 0; end
      default: ;
    endcase
    if (restart || nph != m_ph) m_t = 0;
    m_ph = nph;
  endtask

  function automatic logic [12:0] m_exp();
    logic [4:0] o;
    case (m_ph)
      PH_WAIT, PH_STAB: o = 5'b11100;
      PH_REL:           o = 5'b10100;
      PH_RUN:           o = 5'b10010;
      PH_FAIL:          o = 5'b01101;
      default:          o = 5'b01100;
    endcase
    return {o, 8'(m_loss)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; req_reset = 0; pll_lock = 1'($urandom_range(0, 1));
    repeat (3) tick();
    checks++; if (act !== 13'b0_1_1_0_0_00000000) begin errors++; $display("FAIL reset_state act=%b exp=%b", act, 13'b0_1_1_0_0_00000000); end
    checks++; if (act !== m_exp()) begin errors++; $display("FAIL reset_model act=%h exp=%h", act, m_exp()); end
  endtask

  task automatic test_nominal();
    int rise = -1, core_fall = -1, usb_fall = -1, rdy_rise = -1;
    rst = 1; pll_lock = 0; tick(); tick(); rst = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      checks++; if (act !== m_exp()) begin errors++; $display("FAIL nominal_model t=%0t act=%h exp=%h", $time, act, m_exp()); end
      if (rise < 0 && pll_resetb) rise = i;
      if (rise >= 0 && i == rise + 10) pll_lock = 1;
      if (core_fall < 0 && !rst_core) core_fall = i;
      if (usb_fall < 0 && !rst_usb) usb_fall = i;
      if (rdy_rise < 0 && ready) rdy_rise = i;
    end
    checks++; if (rise !== T_PLL_RST) begin errors++; $display("FAIL nominal_pll_release cyc=%0d exp=%0d", rise, T_PLL_RST); end
    checks++; if (core_fall !== rise + 10 + 1 + 2 + T_STABLE) begin errors++; $display("FAIL nominal_core_release cyc=%0d exp=%0d", core_fall, rise + 13 + T_STABLE); end
    checks++; if (usb_fall !== core_fall + T_STAGGER) begin errors++; $display("FAIL nominal_usb_release cyc=%0d exp=%0d", usb_fall, core_fall + T_STAGGER); end
    checks++; if (rdy_rise !== core_fall + T_STAGGER) begin errors++; $display("FAIL nominal_ready cyc=%0d exp=%0d", rdy_rise, core_fall + T_STAGGER); end
  endtask

  task automatic test_timeout_fail();
    int fail_at = -1, rises = 0;
    bit prev = 0;
    rst = 1; pll_lock = 0; tick(); tick(); rst = 0;
    for (int i = 1; i <= 120 && fail_at < 0; i++) begin
      tick();
      checks++; if (act !== m_exp()) begin errors++; $display("FAIL timeout_model t=%0t act=%h exp=%h", $time, act, m_exp()); end
      if (pll_resetb && !prev) rises++;
      prev = pll_resetb;
      if (fail) fail_at = i;
    end
    checks++; if (fail_at !== 2 * (T_PLL_RST + T_LOCK_TO)) begin errors++; $display("FAIL timeout_fail_cycle cyc=%0d exp=%0d", fail_at, 2 * (T_PLL_RST + T_LOCK_TO)); end
    checks++; if (rises !== MAX_RETRY) begin errors++; $display("FAIL timeout_windows got=%0d exp=%0d", rises, MAX_RETRY); end
    repeat (10) begin
      tick();
      checks++; if (act !== m_exp()) begin errors++; $display("FAIL fail_hold_model t=%0t act=%h exp=%h", $time, act, m_exp()); end
    end
    checks++; if ({fail, pll_resetb} !== 2'b10) begin errors++; $display("FAIL fail_hold fail,resetb=%b exp=10", {fail, pll_resetb}); end
    req_reset = 1; tick(); req_reset = 0;
    checks++; if ({fail, pll_resetb, rst_core} !== 3'b001) begin errors++; $display("FAIL fail_exit got=%b exp=001", {fail, pll_resetb, rst_core}); end
    repeat (71) begin
      tick();
      checks++; if (act !== m_exp()) begin errors++; $display("FAIL retry_model t=%0t act=%h exp=%h", $time, act, m_exp()); end
    end
    checks++; if (pll_resetb !== 1'b1) begin errors++; $display("FAIL retry_window resetb=%b exp=1", pll_resetb); end
    req_reset = 1; tick(); req_reset = 0;
    checks++; if ({fail, pll_resetb} !== 2'b00) begin errors++; $display("FAIL req_vs_timeout fail,resetb=%b exp=00", {fail, pll_resetb}); end
    repeat (10) begin
      tick();
      checks++; if (act !== m_exp()) begin errors++; $display("FAIL req_vs_timeout_model t=%0t act=%h exp=%h", $time, act, m_exp()); end
    end
  endtask

  task automatic test_stable_glitch();
    int k = 0, core_fall = -1;
    rst = 1; pll_lock = 0; tick(); tick(); rst = 0;
    while (!pll_resetb && k < 20) begin tick(); k++; end
    checks++; if (k >= 20) begin errors++; $display("FAIL glitch_setup resetb=%b exp=1", pll_resetb); end
    pll_lock = 1;
    for (int j = 1; j <= 40; j++) begin
      if (j == 7) pll_lock = 0;
      if (j == 10) pll_lock = 1;
      tick();
      checks++; if (act !== m_exp()) begin errors++; $display("FAIL glitch_model t=%0t act=%h exp=%h", $time, act, m_exp()); end
      if (j == 9) begin
        checks++; if ({pll_resetb, rst_core} !== 2'b01) begin errors++; $display("FAIL glitch_prst resetb,core=%b exp=01", {pll_resetb, rst_core}); end
      end
      if (core_fall < 0 && !rst_core) core_fall = j;
    end
    checks++; if (core_fall !== 22) begin errors++; $display("FAIL glitch_release cyc=%0d exp=22", core_fall); end
    checks++; if (lock_loss_cnt !== 8'd0) begin errors++; $display("FAIL glitch_loss_cnt got=%0d exp=0", lock_loss_cnt); end
  endtask

  task automatic test_run_loss();
    int drop_at = -1, k = 0;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL run_pre ready=%b exp=1", ready); end
    for (int j = 1; j <= 8; j++) begin
      pll_lock = j >= 5;
      tick();
      checks++; if (act !== m_exp()) begin errors++; $display("FAIL run_loss_model t=%0t act=%h exp=%h", $time, act, m_exp()); end
      if (drop_at < 0 && {ready, rst_core, rst_usb} === 3'b011) drop_at = j;
    end
    checks++; if (drop_at < 1 || drop_at > 3) begin errors++; $display("FAIL run_loss_latency cyc=%0d exp=1..3", drop_at); end
    checks++; if (lock_loss_cnt !== 8'd1) begin errors++; $display("FAIL run_loss_cnt got=%0d exp=1", lock_loss_cnt); end
    while (!ready && k < 60) begin
      tick(); k++;
      checks++; if (act !== m_exp()) begin errors++; $display("FAIL run_recover_model t=%0t act=%h exp=%h", $time, act, m_exp()); end
    end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL run_recover ready=%b exp=1", ready); end
  endtask

  task automatic test_priority();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL prio_pre ready=%b exp=1", ready); end
    pll_lock = 0; tick(); tick();
    pll_lock = 1; req_reset = 1; tick(); req_reset = 0;
    checks++; if (lock_loss_cnt !== 8'd1) begin errors++; $display("FAIL prio_cnt got=%0d exp=1", lock_loss_cnt); end
    checks++; if ({pll_resetb, rst_core, rst_usb, ready, fail} !== 5'b01100) begin errors++; $display("FAIL prio_prst got=%b exp=01100", {pll_resetb, rst_core, rst_usb, ready, fail}); end
    repeat (30) begin
      tick();
      checks++; if (act !== m_exp()) begin errors++; $display("FAIL prio_model t=%0t act=%h exp=%h", $time, act, m_exp()); end
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 300; n++) begin
      int k = 0;
      while (rst_core && k < 60) begin
        tick(); k++;
        checks++; if (act !== m_exp()) begin errors++; $display("FAIL sat_model t=%0t act=%h exp=%h", $time, act, m_exp()); end
      end
      if (k >= 60) begin
        checks++; errors++; $display("FAIL sat_release_timeout iter=%0d core=%b exp=0", n, rst_core);
        break;
      end
      pll_lock = 0;
      repeat ($urandom_range(2, 4)) tick();
      pll_lock = 1;
      repeat (3) tick();
    end
    checks++; if (lock_loss_cnt !== 8'd255) begin errors++; $display("FAIL sat_cnt got=%0d exp=255", lock_loss_cnt); end
  endtask

  task automatic test_random();
    int run = 0;
    for (int i = 0; i < 2500; i++) begin
      if (run == 0) begin
        pll_lock = ~pll_lock;
        run = pll_lock ? int'($urandom_range(1, 60)) : ($urandom_range(0, 7) == 0 ? 80 : int'($urandom_range(1, 6)));
      end
      run--;
      req_reset = $urandom_range(0, 149) == 0;
      rst = $urandom_range(0, 499) == 0;
      tick();
      checks++; if (act !== m_exp()) begin errors++; $display("FAIL random_model t=%0t act=%h exp=%h", $time, act, m_exp()); end
    end
    rst = 0; req_reset = 0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_timeout_fail();
    test_stable_glitch();
    test_run_loss();
    test_priority();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pll_rst_seq.md
PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 The block SHALL have parameter T_PLL_RST, default 16, cycles PLL is held in reset (>=2).
REQ-002 The block SHALL have parameter T_LOCK_TO, default 4096, lock-wait timeout in cycles (>=4).
REQ-003 The block SHALL have parameter T_STABLE, default 64, consecutive locked cycles required before release (>=1).
REQ-004 The block SHALL have parameter T_STAGGER, default 8, cycles between rst_core and rst_usb release (>=1).
REQ-005 The block SHALL have parameter MAX_RETRY, default 3, lock timeouts tolerated before FAIL (1..15).
REQ-006 The block SHALL have port clk, input, 1, free-running reference clock; the block has one clock and reset is synchronous and active-high.
REQ-007 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 The block SHALL have port req_reset, input, 1, single-cycle request to restart the whole sequence.
REQ-009 The block SHALL have port pll_lock, input, 1, asynchronous PLL lock indication.
REQ-010 The block SHALL have port pll_resetb, output, 1, active-low PLL reset.
REQ-011 The block SHALL have port rst_core, output, 1, active-high core-domain reset request.
REQ-012 The block SHALL have port rst_usb, output, 1, active-high USB-domain reset request.
REQ-013 The block SHALL have port ready, output, 1, high only in RUN.
REQ-014 The block SHALL have port fail, output, 1, high only in FAIL.
REQ-015 The block SHALL have port lock_loss_cnt, output, 8, saturating count of lock losses after release.

Function
REQ-016 pll_lock SHALL pass through a 2-FF synchronizer; "lock" below means the synchronized value (2-cycle latency).
REQ-017 All outputs SHALL be registered and derived from state only, updating the cycle after the state transition.
REQ-018 The states SHALL be PLL_RST, WAIT_LOCK, STABLE, REL_CORE, RUN, FAIL, with one shared down-counter sized for the largest timing parameter.
REQ-019 In PLL_RST: pll_resetb=0, rst_core=1, rst_usb=1, ready=0; after exactly T_PLL_RST cycles SHALL go to WAIT_LOCK.
REQ-020 In WAIT_LOCK: pll_resetb=1, both resets=1; lock high SHALL go to STABLE; T_LOCK_TO cycles without lock SHALL increment retry_cnt and go to PLL_RST, or go to FAIL if retry_cnt+1 == MAX_RETRY.
REQ-021 In STABLE: lock high for T_STABLE consecutive cycles SHALL go to REL_CORE; any low-lock cycle SHALL go to PLL_RST without touching retry_cnt or lock_loss_cnt.
REQ-022 In REL_CORE: rst_core=0, rst_usb=1; after T_STAGGER cycles SHALL go to RUN.
REQ-023 In RUN: rst_core=0, rst_usb=0, ready=1; retry_cnt SHALL clear on RUN entry.
REQ-024 Lock low in REL_CORE or RUN SHALL go to PLL_RST, reasserting both resets the next cycle, and SHALL increment lock_loss_cnt, saturating at 255.
REQ-025 In FAIL: pll_resetb=0, both resets=1, ready=0, fail=1; the block SHALL stay there until req_reset or rst.
REQ-026 req_reset SHALL, from any state, go to PLL_RST and clear retry_cnt; lock_loss_cnt SHALL be cleared only by rst.
REQ-027 When req_reset and a lock loss or timeout occur in the same cycle, req_reset SHALL win: no counter increment and no FAIL entry.
REQ-028 A lock glitch shorter than 2 cycles MAY be missed; any lock low that is visible after synchronization SHALL be acted on.

Reset
REQ-029 While rst=1: state=PLL_RST, counter loaded with T_PLL_RST, pll_resetb=0, rst_core=1, rst_usb=1, ready=0, fail=0, retry_cnt=0, lock_loss_cnt=0, synchronizer=0.
REQ-030 Reset mid-sequence (any state) SHALL abort the sequence with no partial release; the timed sequence SHALL restart from PLL_RST.

Verification (bench params: T_PLL_RST=4, T_LOCK_TO=32, T_STABLE=8, T_STAGGER=4, MAX_RETRY=2)
REQ-031 Nominal: rst release, pll_lock high 10 cycles after pll_resetb rises -> rst_core falls after 2+8 locked cycles; rst_usb and ready follow exactly 4 cycles later.
REQ-032 Timeout/FAIL: pll_lock held low -> two 32-cycle WAIT_LOCK windows with 4-cycle PLL_RST pulses between -> fail=1 and pll_resetb=0 held; then req_reset -> fail=0 and the sequence restarts.
REQ-033 Stable glitch: lock drops for 3 cycles at locked cycle 5 of STABLE -> PLL_RST re-entered, lock_loss_cnt stays 0, and rst_core is not released early.
REQ-034 Run loss: lock drops in RUN -> ready=0, rst_core=1 and rst_usb=1 within 3 cycles of the drop, lock_loss_cnt=1; the sequence recovers when lock returns.
REQ-035 Saturation/priority: 300 lock losses -> lock_loss_cnt=255; req_reset coincident with a lock loss -> count unchanged and PLL_RST entered.
